// File: rtl/core_pkg.sv
// Shared definitions for the MIPS-style core: default widths, immediate
// selector encodings and the ID/EX control bundle.
package core_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int RA_W_DEFAULT   = 5;
    localparam int ALUC_W_DEFAULT = 3;

    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        IMM_SEXT16 = 2'b00,
        IMM_ZEXT16 = 2'b01,
        IMM_LUI16  = 2'b10,
        IMM_JUMP26 = 2'b11
    } imm_src_e;

    typedef struct packed {
        logic reg_write;
        logic alu_src;
        logic mem_write;
        logic result_src;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, alu_src: 1'b0,
                                      mem_write: 1'b0, result_src: 1'b0};

endpackage

// File: rtl/reg_file_p.sv
// Two-read, one-write register file with synchronous clear and a
// write-before-read bypass so a writeback is visible in the same cycle.
module reg_file_p
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RA_W = RA_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] a1,
    input  logic [RA_W-1:0] a2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [RA_W-1:0] wa,
    input  logic [XLEN-1:0] wd
);

    localparam int NREGS = 2 ** RA_W;
    localparam logic [RA_W-1:0] ZERO_ADDR = RA_W'(REG_ZERO);

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0][XLEN-1:0] regs_d;
    logic                       wr_en;

    // Writes to the zero register are dropped so it can never hold data.
    always_comb begin
        wr_en = we && (wa != ZERO_ADDR);
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1 = regs_q[a1];
        if (a1 == ZERO_ADDR) begin
            rd1 = '0;
        end else if (wr_en && (wa == a1)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs_q[a2];
        if (a2 == ZERO_ADDR) begin
            rd2 = '0;
        end else if (wr_en && (wa == a2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/decode_stage_p.sv
// ID stage of the 5-stage core: register read, immediate extension, branch
// target, load-use detection and the ID/EX pipeline register.
module decode_stage_p
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int RA_W   = RA_W_DEFAULT,
    parameter int ALUC_W = ALUC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              RegWriteD,
    input  logic              ALUSrcD,
    input  logic              MemWriteD,
    input  logic              ResultSrcD,
    input  logic              DstSrcD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic [1:0]        ImmSrcD,
    input  logic              FlushE,
    input  logic              RegWriteW,
    input  logic [RA_W-1:0]   RDW,
    input  logic [XLEN-1:0]   ResultW,
    output logic              StallD,
    output logic              RegWriteE,
    output logic              ALUSrcE,
    output logic              MemWriteE,
    output logic              ResultSrcE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [XLEN-1:0]   RD1_E,
    output logic [XLEN-1:0]   RD2_E,
    output logic [XLEN-1:0]   Imm_Ext_E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [XLEN-1:0]   PCTargetE,
    output logic [RA_W-1:0]   RS1_E,
    output logic [RA_W-1:0]   RS2_E,
    output logic [RA_W-1:0]   RD_E
);

    localparam logic [RA_W-1:0] ZERO_ADDR = RA_W'(REG_ZERO);

    logic [RA_W-1:0]   a1;
    logic [RA_W-1:0]   a2;
    logic [RA_W-1:0]   rd_sel;
    logic [XLEN-1:0]   rf_rd1;
    logic [XLEN-1:0]   rf_rd2;
    logic [XLEN-1:0]   imm_ext;
    logic              stall;
    logic              bubble;
    logic [5:0]        unused_opcode;

    ctrl_t             ctrl_d,        ctrl_q;
    logic [ALUC_W-1:0] alu_control_d, alu_control_q;
    logic [XLEN-1:0]   rd1_d,         rd1_q;
    logic [XLEN-1:0]   rd2_d,         rd2_q;
    logic [XLEN-1:0]   imm_ext_d,     imm_ext_q;
    logic [XLEN-1:0]   pc_d,          pc_q;
    logic [XLEN-1:0]   pc_plus4_d,    pc_plus4_q;
    logic [XLEN-1:0]   pc_target_d,   pc_target_q;
    logic [RA_W-1:0]   rs1_d,         rs1_q;
    logic [RA_W-1:0]   rs2_d,         rs2_q;
    logic [RA_W-1:0]   rd_d,          rd_q;

    always_comb begin
        a1            = RA_W'(InstrD[25:21]);
        a2            = RA_W'(InstrD[20:16]);
        rd_sel        = DstSrcD ? RA_W'(InstrD[15:11]) : RA_W'(InstrD[20:16]);
        unused_opcode = InstrD[31:26];
    end

    reg_file_p #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) u_reg_file (
        .clk (clk),
        .rst (rst),
        .a1  (a1),
        .a2  (a2),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (RegWriteW),
        .wa  (RDW),
        .wd  (ResultW)
    );

    // Upper bits are cleared first so the narrower forms need no zero-width replication.
    always_comb begin
        imm_ext = '0;
        case (imm_src_e'(ImmSrcD))
            IMM_SEXT16: imm_ext = {{(XLEN-16){InstrD[15]}}, InstrD[15:0]};
            IMM_ZEXT16: imm_ext[15:0]  = InstrD[15:0];
            IMM_LUI16:  imm_ext[31:16] = InstrD[15:0];
            IMM_JUMP26: imm_ext[27:2]  = InstrD[25:0];
            default:    imm_ext = '0;
        endcase
    end

    // A load in E whose destination is read in D must wait one cycle for the data.
    always_comb begin
        stall  = ctrl_q.result_src && ctrl_q.reg_write && (rd_q != ZERO_ADDR) &&
                 ((rd_q == a1) || (rd_q == a2));
        bubble = stall || FlushE;
    end

    always_comb begin
        ctrl_d        = '{reg_write: RegWriteD, alu_src: ALUSrcD,
                          mem_write: MemWriteD, result_src: ResultSrcD};
        alu_control_d = ALUControlD;
        if (bubble) begin
            ctrl_d        = CTRL_BUBBLE;
            alu_control_d = '0;
        end
        rd1_d       = rf_rd1;
        rd2_d       = rf_rd2;
        imm_ext_d   = imm_ext;
        pc_d        = PCD;
        pc_plus4_d  = PCPlus4D;
        pc_target_d = PCD + (imm_ext << 2);
        rs1_d       = a1;
        rs2_d       = a2;
        rd_d        = rd_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q        <= CTRL_BUBBLE;
            alu_control_q <= '0;
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_ext_q     <= '0;
            pc_q          <= '0;
            pc_plus4_q    <= '0;
            pc_target_q   <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            alu_control_q <= alu_control_d;
            rd1_q         <= rd1_d;
            rd2_q         <= rd2_d;
            imm_ext_q     <= imm_ext_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            pc_target_q   <= pc_target_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
        end
    end

    always_comb begin
        StallD      = stall;
        RegWriteE   = ctrl_q.reg_write;
        ALUSrcE     = ctrl_q.alu_src;
        MemWriteE   = ctrl_q.mem_write;
        ResultSrcE  = ctrl_q.result_src;
        ALUControlE = alu_control_q;
        RD1_E       = rd1_q;
        RD2_E       = rd2_q;
        Imm_Ext_E   = imm_ext_q;
        PCE         = pc_q;
        PCPlus4E    = pc_plus4_q;
        PCTargetE   = pc_target_q;
        RS1_E       = rs1_q;
        RS2_E       = rs2_q;
        RD_E        = rd_q;
    end

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed testbench for decode_stage_p: reset, register file bypass, x0,
// load-use stall, flush/bubble, branch target and immediate forms.
module tb_decode_stage_p;

    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int ALUC_W = 3;

    // Control bundles ordered {RegWrite, ALUSrc, MemWrite, ResultSrc, DstSrc}.
    localparam logic [4:0] C_NONE   = 5'b00000;
    localparam logic [4:0] C_RTYPE  = 5'b10001;
    localparam logic [4:0] C_LOAD   = 5'b11010;
    localparam logic [4:0] C_STORE  = 5'b01100;
    localparam logic [4:0] C_ALUI   = 5'b11000;

    logic              clk;
    logic              rst;
    logic [31:0]       InstrD;
    logic [XLEN-1:0]   PCD;
    logic [XLEN-1:0]   PCPlus4D;
    logic              RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, DstSrcD;
    logic [ALUC_W-1:0] ALUControlD;
    logic [1:0]        ImmSrcD;
    logic              FlushE;
    logic              RegWriteW;
    logic [RA_W-1:0]   RDW;
    logic [XLEN-1:0]   ResultW;
    logic              StallD;
    logic              RegWriteE, ALUSrcE, MemWriteE, ResultSrcE;
    logic [ALUC_W-1:0] ALUControlE;
    logic [XLEN-1:0]   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, PCTargetE;
    logic [RA_W-1:0]   RS1_E, RS2_E, RD_E;

    int checks;
    int errors;

    decode_stage_p #(
        .XLEN   (XLEN),
        .RA_W   (RA_W),
        .ALUC_W (ALUC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .RegWriteD   (RegWriteD),
        .ALUSrcD     (ALUSrcD),
        .MemWriteD   (MemWriteD),
        .ResultSrcD  (ResultSrcD),
        .DstSrcD     (DstSrcD),
        .ALUControlD (ALUControlD),
        .ImmSrcD     (ImmSrcD),
        .FlushE      (FlushE),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
        .StallD      (StallD),
        .RegWriteE   (RegWriteE),
        .ALUSrcE     (ALUSrcE),
        .MemWriteE   (MemWriteE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .Imm_Ext_E   (Imm_Ext_E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .PCTargetE   (PCTargetE),
        .RS1_E       (RS1_E),
        .RS2_E       (RS2_E),
        .RD_E        (RD_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, 6'h20};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [4:0] ctrl, input logic [2:0] aluc,
                                 input logic [1:0] imm_src, input logic flush);
        InstrD      = instr;
        PCD         = pc;
        PCPlus4D    = pc + 32'd4;
        {RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, DstSrcD} = ctrl;
        ALUControlD = aluc;
        ImmSrcD     = imm_src;
        FlushE      = flush;
    endtask

    task automatic setWriteback(input logic we, input logic [4:0] rd, input logic [31:0] data);
        RegWriteW = we;
        RDW       = rd;
        ResultW   = data;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(32'h0, 32'h0, C_NONE, 3'd0, 2'd0, 1'b0);
        setWriteback(1'b0, 5'd0, 32'h0);

        // Reset with random inputs, including writeback attempts.
        repeat (2) begin
            InstrD      = $urandom;
            PCD         = $urandom;
            PCPlus4D    = $urandom;
            {RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, DstSrcD} = 5'($urandom);
            ALUControlD = 3'($urandom);
            ImmSrcD     = 2'($urandom);
            FlushE      = 1'($urandom);
            setWriteback(1'b1, 5'($urandom_range(1, 31)), $urandom);
            stepClock();
        end
        checkOutput("rst_RegWriteE",   32'(RegWriteE),   32'h0);
        checkOutput("rst_ALUSrcE",     32'(ALUSrcE),     32'h0);
        checkOutput("rst_MemWriteE",   32'(MemWriteE),   32'h0);
        checkOutput("rst_ResultSrcE",  32'(ResultSrcE),  32'h0);
        checkOutput("rst_ALUControlE", 32'(ALUControlE), 32'h0);
        checkOutput("rst_RD1_E",       RD1_E,            32'h0);
        checkOutput("rst_RD2_E",       RD2_E,            32'h0);
        checkOutput("rst_Imm_Ext_E",   Imm_Ext_E,        32'h0);
        checkOutput("rst_PCE",         PCE,              32'h0);
        checkOutput("rst_PCPlus4E",    PCPlus4E,         32'h0);
        checkOutput("rst_PCTargetE",   PCTargetE,        32'h0);
        checkOutput("rst_RS1_E",       32'(RS1_E),       32'h0);
        checkOutput("rst_RS2_E",       32'(RS2_E),       32'h0);
        checkOutput("rst_RD_E",        32'(RD_E),        32'h0);
        checkOutput("rst_StallD",      32'(StallD),      32'h0);

        rst = 1'b0;
        setWriteback(1'b0, 5'd0, 32'h0);
        for (int r = 1; r < 32; r++) begin
            applyStimulus(r_type(5'(r), 5'(r), 5'd0), 32'h0, C_NONE, 3'd0, 2'd0, 1'b0);
            stepClock();
            checkOutput($sformatf("rst_r%0d_rd1", r), RD1_E, 32'h0);
            checkOutput($sformatf("rst_r%0d_rd2", r), RD2_E, 32'h0);
        end

        // Same-cycle bypass, then the stored value.
        setWriteback(1'b1, 5'd5, 32'hDEADBEEF);
        applyStimulus(r_type(5'd5, 5'd0, 5'd0), 32'h40, C_RTYPE, 3'b010, 2'd0, 1'b0);
        stepClock();
        checkOutput("bypass_RD1_E",      RD1_E,            32'hDEADBEEF);
        checkOutput("bypass_RD2_E",      RD2_E,            32'h0);
        checkOutput("bypass_RS1_E",      32'(RS1_E),       32'd5);
        checkOutput("bypass_RegWriteE",  32'(RegWriteE),   32'h1);
        checkOutput("bypass_ALUControl", 32'(ALUControlE), 32'h2);
        checkOutput("bypass_PCPlus4E",   PCPlus4E,         32'h44);
        setWriteback(1'b0, 5'd0, 32'h0);
        applyStimulus(r_type(5'd0, 5'd5, 5'd6), 32'h44, C_RTYPE, 3'b010, 2'd0, 1'b0);
        stepClock();
        checkOutput("stored_RD2_E", RD2_E,      32'hDEADBEEF);
        checkOutput("stored_RD1_E", RD1_E,      32'h0);
        checkOutput("rtype_RD_E",   32'(RD_E),  32'd6);
        checkOutput("rtype_RS2_E",  32'(RS2_E), 32'd5);

        // Register zero ignores writes and never triggers a stall.
        setWriteback(1'b1, 5'd0, 32'h1234);
        applyStimulus(r_type(5'd0, 5'd0, 5'd1), 32'h48, C_RTYPE, 3'b010, 2'd0, 1'b0);
        stepClock();
        checkOutput("x0_bypass_RD1_E", RD1_E, 32'h0);
        setWriteback(1'b0, 5'd0, 32'h0);
        stepClock();
        checkOutput("x0_stored_RD1_E", RD1_E, 32'h0);
        applyStimulus(i_type(6'h23, 5'd0, 5'd0, 16'h0004), 32'h4C, C_LOAD, 3'b010, 2'd0, 1'b0);
        stepClock();
        checkOutput("x0_load_ResultSrcE", 32'(ResultSrcE), 32'h1);
        checkOutput("x0_load_RD_E",       32'(RD_E),       32'd0);
        applyStimulus(r_type(5'd0, 5'd0, 5'd2), 32'h50, C_RTYPE, 3'b010, 2'd0, 1'b0);
        #1;
        checkOutput("x0_no_stall", 32'(StallD), 32'h0);
        stepClock();
        checkOutput("x0_no_bubble", 32'(RegWriteE), 32'h1);

        // Load-use: lw $8 then add $9,$8,$3.
        setWriteback(1'b1, 5'd3, 32'h33);
        applyStimulus(i_type(6'h23, 5'd2, 5'd8, 16'h0004), 32'h60, C_LOAD, 3'b010, 2'd0, 1'b0);
        stepClock();
        setWriteback(1'b0, 5'd0, 32'h0);
        checkOutput("lw_RD_E",      32'(RD_E),    32'd8);
        checkOutput("lw_ALUSrcE",   32'(ALUSrcE), 32'h1);
        checkOutput("lw_Imm_Ext_E", Imm_Ext_E,    32'h4);
        checkOutput("lw_PCTargetE", PCTargetE,    32'h70);
        applyStimulus(r_type(5'd8, 5'd3, 5'd9), 32'h64, C_RTYPE, 3'b010, 2'd0, 1'b0);
        #1;
        checkOutput("lu_StallD", 32'(StallD), 32'h1);
        stepClock();
        checkOutput("lu_bubble_RegWriteE",  32'(RegWriteE),   32'h0);
        checkOutput("lu_bubble_ResultSrcE", 32'(ResultSrcE),  32'h0);
        checkOutput("lu_bubble_ALUControl", 32'(ALUControlE), 32'h0);
        checkOutput("lu_stall_cleared",     32'(StallD),      32'h0);
        setWriteback(1'b1, 5'd8, 32'h88);
        stepClock();
        setWriteback(1'b0, 5'd0, 32'h0);
        checkOutput("lu_add_RegWriteE",  32'(RegWriteE),   32'h1);
        checkOutput("lu_add_RD_E",       32'(RD_E),        32'd9);
        checkOutput("lu_add_RD1_E",      RD1_E,            32'h88);
        checkOutput("lu_add_RD2_E",      RD2_E,            32'h33);
        checkOutput("lu_add_ALUControl", 32'(ALUControlE), 32'h2);
        checkOutput("lu_add_PCE",        PCE,              32'h64);
        checkOutput("lu_add_StallD",     32'(StallD),      32'h0);

        // Store passes MemWrite through.
        applyStimulus(i_type(6'h2B, 5'd0, 5'd3, 16'h0008), 32'h68, C_STORE, 3'b010, 2'd0, 1'b0);
        stepClock();
        checkOutput("sw_MemWriteE", 32'(MemWriteE), 32'h1);
        checkOutput("sw_RegWriteE", 32'(RegWriteE), 32'h0);
        checkOutput("sw_RD2_E",     RD2_E,          32'h33);

        // Branch target with negative offset.
        applyStimulus(i_type(6'h04, 5'd1, 5'd2, 16'hFFFF), 32'h100, C_NONE, 3'b110, 2'b00, 1'b0);
        stepClock();
        checkOutput("beq_PCTargetE",   PCTargetE,        32'hFC);
        checkOutput("beq_Imm_Ext_E",   Imm_Ext_E,        32'hFFFFFFFF);
        checkOutput("beq_PCE",         PCE,              32'h100);
        checkOutput("beq_PCPlus4E",    PCPlus4E,         32'h104);
        checkOutput("beq_ALUControlE", 32'(ALUControlE), 32'h6);

        // Flush alone.
        applyStimulus(r_type(5'd1, 5'd2, 5'd3), 32'h104, C_RTYPE, 3'b010, 2'd0, 1'b1);
        stepClock();
        checkOutput("flush_RegWriteE",   32'(RegWriteE),   32'h0);
        checkOutput("flush_ALUControlE", 32'(ALUControlE), 32'h0);

        // Flush coinciding with a load-use stall gives one bubble.
        applyStimulus(i_type(6'h23, 5'd0, 5'd10, 16'h0000), 32'h200, C_LOAD, 3'b010, 2'd0, 1'b0);
        stepClock();
        applyStimulus(r_type(5'd10, 5'd0, 5'd11), 32'h204, C_RTYPE, 3'b010, 2'd0, 1'b1);
        #1;
        checkOutput("fs_StallD", 32'(StallD), 32'h1);
        stepClock();
        FlushE = 1'b0;
        #1;
        checkOutput("fs_bubble_RegWriteE", 32'(RegWriteE), 32'h0);
        checkOutput("fs_stall_cleared",    32'(StallD),    32'h0);
        stepClock();
        checkOutput("fs_add_RegWriteE", 32'(RegWriteE), 32'h1);
        checkOutput("fs_add_RD_E",      32'(RD_E),      32'd11);
        checkOutput("fs_add_PCE",       PCE,            32'h204);
        applyStimulus(32'h0, 32'h208, C_NONE, 3'd0, 2'd0, 1'b0);
        stepClock();
        checkOutput("fs_next_PCE",       PCE,            32'h208);
        checkOutput("fs_next_RegWriteE", 32'(RegWriteE), 32'h0);

        // Destination select and immediate forms.
        applyStimulus(i_type(6'h0F, 5'd4, 5'd7, 16'h8001), 32'h10, C_ALUI, 3'b010, 2'b10, 1'b0);
        stepClock();
        checkOutput("lui_RD_E",      32'(RD_E), 32'd7);
        checkOutput("lui_Imm_Ext_E", Imm_Ext_E, 32'h80010000);
        checkOutput("lui_PCTargetE", PCTargetE, 32'h00040010);
        applyStimulus(i_type(6'h0D, 5'd4, 5'd7, 16'h8001), 32'h10, C_ALUI, 3'b001, 2'b01, 1'b0);
        stepClock();
        checkOutput("zext_Imm_Ext_E", Imm_Ext_E, 32'h00008001);
        checkOutput("zext_PCTargetE", PCTargetE, 32'h00020014);
        applyStimulus(i_type(6'h08, 5'd4, 5'd7, 16'h8001), 32'h10, C_ALUI, 3'b010, 2'b00, 1'b0);
        stepClock();
        checkOutput("sext_Imm_Ext_E", Imm_Ext_E, 32'hFFFF8001);
        checkOutput("sext_PCTargetE", PCTargetE, 32'hFFFE0014);
        applyStimulus({6'h02, 26'h3FFFFFF}, 32'h10, C_NONE, 3'd0, 2'b11, 1'b0);
        stepClock();
        checkOutput("jump_Imm_Ext_E", Imm_Ext_E, 32'h0FFFFFFC);
        checkOutput("jump_PCTargetE", PCTargetE, 32'h40000000);
        applyStimulus(i_type(6'h0D, 5'd0, 5'd1, 16'h0008), 32'hFFFFFFF0, C_ALUI, 3'd0, 2'b01, 1'b0);
        stepClock();
        checkOutput("wrap_PCTargetE", PCTargetE, 32'h00000010);

        // Reset in the middle of a stall drops everything, register file included.
        applyStimulus(i_type(6'h23, 5'd0, 5'd12, 16'h0000), 32'h300, C_LOAD, 3'b010, 2'd0, 1'b0);
        stepClock();
        applyStimulus(r_type(5'd12, 5'd0, 5'd13), 32'h304, C_RTYPE, 3'b010, 2'd0, 1'b0);
        #1;
        checkOutput("mrst_StallD_before", 32'(StallD), 32'h1);
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        checkOutput("mrst_RegWriteE",  32'(RegWriteE),  32'h0);
        checkOutput("mrst_ResultSrcE", 32'(ResultSrcE), 32'h0);
        checkOutput("mrst_RD_E",       32'(RD_E),       32'd0);
        checkOutput("mrst_PCE",        PCE,             32'h0);
        checkOutput("mrst_StallD",     32'(StallD),     32'h0);
        applyStimulus(r_type(5'd5, 5'd8, 5'd0), 32'h0, C_NONE, 3'd0, 2'd0, 1'b0);
        stepClock();
        checkOutput("mrst_r5_cleared", RD1_E, 32'h0);
        checkOutput("mrst_r8_cleared", RD2_E, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
